pixel_scanner: RTL and testbench
================================

# pixel_scanner

Frame-level pixel sequencer that sits directly upstream of `ray_generator` in the ray-marcher pipeline. On a start command it walks the screen in raster order and presents one `(screen_x, screen_y)` pair per accepted handshake on the `coords_valid` interface that `ray_generator` consumes. A `coords_ready` input lets downstream stages stall the scan. The block reports busy status, end-of-line and end-of-frame markers, a frame-done pulse and a running frame count.

## Interface
- `SCREEN_WIDTH`, default 640: pixels per line; instantiated with `` `SCREEN_WIDTH ``; must be ≥ 1.
- `SCREEN_HEIGHT`, default 480: lines per frame; instantiated with `` `SCREEN_HEIGHT ``; must be ≥ 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- `continuous`  in  1  when high at the end of a frame, the next frame starts immediately without returning to IDLE.
- `abort`  in  1  terminates any scan in progress.
- `coords_ready`  in  1  downstream can accept the current coordinate.
- `screen_x`  out  32 (`fp`)  current column index, unsigned integer, zero-extended (raw, not Q8.24-scaled).
- `screen_y`  out  32 (`fp`)  current row index, same encoding as `screen_x`.
- `coords_valid`  out  1  `screen_x` and `screen_y` are valid.
- `line_last`  out  1  qualifies the current beat as `screen_x == SCREEN_WIDTH-1`.
- `frame_last`  out  1  qualifies the current beat as the last pixel of the frame.
- `busy`  out  1  high in SCAN.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- `frame_count`  out  16  number of completed frames; wraps modulo 2^16.

## Operation
- Internal counters `x_cnt` and `y_cnt` are max(1, $clog2(N)) bits wide. They are zero-extended onto the 32-bit outputs.
- A beat is accepted on any cycle where `coords_valid && coords_ready`.
- States:
  - **IDLE**
    - `coords_valid = 0`, `busy = 0`.
    - `start` loads x = 0, y = 0 and moves to SCAN.
  - **SCAN**
    - `coords_valid = 1`, `busy = 1`.
    - On an accepted beat:
      - If x < W-1: x = x+1.
      - Else: x = 0 and y = y+1.
      - If the beat is the last pixel (x == W-1 and y == H-1): x = 0, y = 0, `frame_count` increments, and `frame_done` pulses on the next cycle.
        - If `continuous == 1`: remain in SCAN.
        - Otherwise: go to IDLE.
    - With no accepted beat, `screen_x`, `screen_y`, `line_last` and `frame_last` hold stable. Once asserted, `coords_valid` does not drop except on `abort` or reset.
- `start` while in SCAN is ignored.
- `abort`, whether or not it coincides with a handshake:
  - Next cycle: IDLE, `coords_valid = 0`, counters cleared.
  - No `frame_done` pulse and no `frame_count` increment, even if the last pixel was accepted in the same cycle. Abort has priority.
- `start` and `abort` in the same IDLE cycle: abort wins and the block stays in IDLE.
- `continuous` is sampled only on the last-pixel handshake.
- W = 1 or H = 1: `line_last` and/or `frame_last` are asserted on every applicable beat; no special casing beyond that.
- `ray_generator` has no ready signal. When it is connected directly, `coords_ready` is tied high and the scan emits one pixel per cycle.

## Timing
- Reset (asynchronous, `rst = 0`) forces:
  - state IDLE
  - `coords_valid = 0`, `busy = 0`, `frame_done = 0`
  - `screen_x = 0`, `screen_y = 0`
  - `line_last = 0`, `frame_last = 0`
  - `frame_count = 0`
- Reset asserted mid-frame discards the frame with no `frame_done`.
- All outputs are registered.
- `start` sampled at edge N gives `coords_valid = 1` with (0,0) after edge N, i.e. 1-cycle latency.
- Throughput is 1 pixel/cycle with `coords_ready` held high. A full frame occupies W·H cycles.
- `frame_done` is high for exactly the cycle after the edge that accepted the last pixel.
  - `frame_count` updates on that same edge.
- In continuous mode, pixel (0,0) of the next frame is valid on the cycle immediately after the last pixel is accepted, so there is no bubble.
- Non-continuous: `busy` falls on the same edge on which `frame_done` rises. A new `start` is accepted in that cycle.

## Test plan
Run all scenarios with `SCREEN_WIDTH = 4` and `SCREEN_HEIGHT = 3`.

1. **Reset values.** Reset, then release `rst`. All outputs are 0, `busy = 0`. Then pulse `start` with `coords_ready = 1`. Expect 12 consecutive beats in order (0,0), (1,0), (2,0), (3,0), (0,1) … (3,2). `line_last` is high on x = 3 only; `frame_last` is high on (3,2) only. `frame_done` pulses at cycle 13 and `frame_count` becomes 1.
2. **Backpressure.** Hold `coords_ready = 0` for 5 cycles while at (2,1). Coordinates stay at (2,1) and `coords_valid` stays 1. Release: the next beat is (3,1). Toggle `coords_ready` every cycle: still exactly 12 accepted beats and one `frame_done`.
3. **Continuous mode.** Set `continuous = 1` and `start`. After (3,2) the next cycle shows (0,0) with `coords_valid = 1`. Two `frame_done` pulses 12 cycles apart; `frame_count` goes to 1, then 2.
4. **Abort.**
   - Abort at (1,1): `coords_valid = 0` and `busy = 0` next cycle; no `frame_done`; `frame_count` unchanged.
   - Abort coinciding with the (3,2) handshake: `frame_count` unchanged, no pulse.
5. **Start edge cases.** `start` during SCAN is ignored and the sequence is unbroken. `start` in the `frame_done` cycle begins a new frame at (0,0) on the next cycle.
6. **Async reset mid-frame.** Assert `rst = 0` between clock edges at pixel (2,2). Outputs clear immediately, without waiting for a clock edge, and `frame_count` reads 0.

Source files
------------

// File: rtl/pixel_scanner_if.sv
// Coordinate stream between pixel_scanner and its consumer (ray_generator).
// Combinational bundle only; no state.
// Consumer stalls the stream by deasserting coords_ready.
interface pixel_scanner_if;
  logic [31:0] screen_x;
  logic [31:0] screen_y;
  logic        coords_valid;
  logic        coords_ready;
  logic        line_last;
  logic        frame_last;

  // Producer side: the scanner drives coordinates and markers.
  modport master (
    output screen_x,
    output screen_y,
    output coords_valid,
    output line_last,
    output frame_last,
    input  coords_ready
  );

  // Consumer side: accepts coordinates, drives ready.
  modport slave (
    input  screen_x,
    input  screen_y,
    input  coords_valid,
    input  line_last,
    input  frame_last,
    output coords_ready
  );
endinterface

// File: rtl/pixel_scanner.sv
// Raster-order pixel sequencer feeding (screen_x, screen_y) to ray_generator.
// Latency: start -> first coordinate valid 1 cycle; 1 pixel/cycle with ready held high.
// Backpressure: coords_ready low holds coordinates and markers stable; valid never drops except on abort/reset.
module pixel_scanner #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   abort,
  pixel_scanner_if.master        coords,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            frame_count
);

  // Counter widths; a 1-pixel dimension still gets a 1-bit counter.
  localparam int XW = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
  localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;

  localparam logic [XW-1:0] X_MAX = XW'(SCREEN_WIDTH  - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_HEIGHT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t         state_q,       state_d;
  logic [XW-1:0]  x_cnt_q,       x_cnt_d;
  logic [YW-1:0]  y_cnt_q,       y_cnt_d;
  logic           valid_q,       valid_d;
  logic           busy_q,        busy_d;
  logic           line_last_q,   line_last_d;
  logic           frame_last_q,  frame_last_d;
  logic           frame_done_q,  frame_done_d;
  logic [15:0]    frame_count_q, frame_count_d;

  logic           accept;
  logic           last_pixel;

  // Handshake and end-of-frame detection on the current (registered) beat.
  assign accept     = valid_q && coords.coords_ready;
  assign last_pixel = (x_cnt_q == X_MAX) && (y_cnt_q == Y_MAX);

  // Next-state: abort overrides everything; markers are derived from the next
  // counter values so they are registered alongside the coordinates.
  always_comb begin
    state_d       = state_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    if (abort) begin
      state_d = IDLE;
      x_cnt_d = '0;
      y_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SCAN;
            x_cnt_d = '0;
            y_cnt_d = '0;
          end
        end
        SCAN: begin
          if (accept) begin
            if (last_pixel) begin
              x_cnt_d       = '0;
              y_cnt_d       = '0;
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              state_d       = continuous ? SCAN : IDLE;
            end else if (x_cnt_q != X_MAX) begin
              x_cnt_d = x_cnt_q + XW'(1);
            end else begin
              x_cnt_d = '0;
              y_cnt_d = y_cnt_q + YW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    valid_d      = (state_d == SCAN);
    busy_d       = (state_d == SCAN);
    line_last_d  = valid_d && (x_cnt_d == X_MAX);
    frame_last_d = line_last_d && (y_cnt_d == Y_MAX);
  end

  // Single register stage for state, counters and every output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      line_last_q   <= 1'b0;
      frame_last_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      line_last_q   <= line_last_d;
      frame_last_q  <= frame_last_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign coords.screen_x     = 32'(x_cnt_q);
  assign coords.screen_y     = 32'(y_cnt_q);
  assign coords.coords_valid = valid_q;
  assign coords.line_last    = line_last_q;
  assign coords.frame_last   = frame_last_q;
  assign busy                = busy_q;
  assign frame_done          = frame_done_q;
  assign frame_count         = frame_count_q;

  // A stalled beat must be held unchanged on the following cycle.
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst)
    (coords.coords_valid && !coords.coords_ready && !abort) |=>
      (coords.coords_valid && $stable(coords.screen_x) && $stable(coords.screen_y)));

endmodule

// File: tb/tb_pixel_scanner.sv
module tb_pixel_scanner;
  localparam int W = 4;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  pixel_scanner_if coords();

  pixel_scanner #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .continuous  (continuous),
    .abort       (abort),
    .coords      (coords),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic  st, co, ab, rdy;
    logic  vld;
    int    x, y;
    logic  bsy, done;
    int    cnt;
  } vec_t;

  vec_t tbl[$];
  int   fc;
  int   checks = 0;
  int   errors = 0;

  function automatic void add(string tag, logic st, logic co, logic ab, logic rdy,
                              logic vld, int x, int y, logic bsy, logic done, int cnt);
    vec_t v;
    v.tag = tag; v.st = st; v.co = co; v.ab = ab; v.rdy = rdy;
    v.vld = vld; v.x = x; v.y = y; v.bsy = bsy; v.done = done; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  // Scan beat showing raster pixel p after the edge.
  function automatic void pix(string tag, int p, logic st, logic co, logic rdy);
    add(tag, st, co, 1'b0, rdy, 1'b1, p % W, p / W, 1'b1, 1'b0, fc);
  endfunction

  // Idle beat (coordinates back at origin).
  function automatic void idle(string tag, logic st, logic ab, logic done);
    add(tag, st, 1'b0, ab, 1'b1, 1'b0, 0, 0, 1'b0, done, fc);
  endfunction

  task automatic check(string name, logic vld, int x, int y, logic bsy, logic done, int cnt);
    logic ll, fl;
    ll = vld && (x == W - 1);
    fl = ll && (y == H - 1);
    checks++;
    if (coords.coords_valid !== vld || coords.screen_x !== 32'(x) || coords.screen_y !== 32'(y) ||
        coords.line_last !== ll || coords.frame_last !== fl || busy !== bsy ||
        frame_done !== done || frame_count !== 16'(cnt)) begin
      errors++;
      $display("FAIL %s: got vld=%0b x=%0d y=%0d ll=%0b fl=%0b busy=%0b done=%0b cnt=%0d, want vld=%0b x=%0d y=%0d ll=%0b fl=%0b busy=%0b done=%0b cnt=%0d",
               name, coords.coords_valid, coords.screen_x, coords.screen_y, coords.line_last,
               coords.frame_last, busy, frame_done, frame_count,
               vld, x, y, ll, fl, bsy, done, cnt);
    end
  endtask

  task automatic step(vec_t v);
    start = v.st; continuous = v.co; abort = v.ab; coords.coords_ready = v.rdy;
    @(posedge clk);
    #1;
    check(v.tag, v.vld, v.x, v.y, v.bsy, v.done, v.cnt);
  endtask

  initial begin
    coords.coords_ready = 1'b1;

    // ---- vector table ----
    fc = 0;
    idle("rst_release", 1'b0, 1'b0, 1'b0);

    // Full frame, ready held high.
    pix("s1_start", 0, 1'b1, 1'b0, 1'b1);
    for (int p = 1; p < W * H; p++) pix("s1_pix", p, 1'b0, 1'b0, 1'b1);
    fc++;
    idle("s1_done", 1'b0, 1'b0, 1'b1);
    idle("s1_idle", 1'b0, 1'b0, 1'b0);

    // Backpressure: 5-cycle stall at (2,1), then ready toggling.
    pix("s2_start", 0, 1'b1, 1'b0, 1'b1);
    for (int p = 1; p <= 6; p++) pix("s2_pix", p, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) pix("s2_stall", 6, 1'b0, 1'b0, 1'b0);
    pix("s2_resume", 7, 1'b0, 1'b0, 1'b1);
    for (int p = 8; p < W * H; p++) begin
      pix("s2_tog_hold", p - 1, 1'b0, 1'b0, 1'b0);
      pix("s2_tog_go", p, 1'b0, 1'b0, 1'b1);
    end
    pix("s2_last_hold", W * H - 1, 1'b0, 1'b0, 1'b0);
    fc++;
    idle("s2_done", 1'b0, 1'b0, 1'b1);
    idle("s2_idle", 1'b0, 1'b0, 1'b0);

    // Continuous: no bubble between frames; continuous only matters on the last beat.
    pix("s3_start", 0, 1'b1, 1'b1, 1'b1);
    for (int p = 1; p < W * H; p++) pix("s3_pix_a", p, 1'b0, 1'b1, 1'b1);
    fc++;
    add("s3_wrap", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, fc);
    for (int p = 1; p < W * H; p++) pix("s3_pix_b", p, 1'b0, (p < 6) ? 1'b1 : 1'b0, 1'b1);
    fc++;
    idle("s3_done", 1'b0, 1'b0, 1'b1);
    idle("s3_idle", 1'b0, 1'b0, 1'b0);

    // Abort at (1,1).
    pix("s4_start", 0, 1'b1, 1'b0, 1'b1);
    for (int p = 1; p <= 5; p++) pix("s4_pix", p, 1'b0, 1'b0, 1'b1);
    idle("s4_abort", 1'b0, 1'b1, 1'b0);
    idle("s4_idle", 1'b0, 1'b0, 1'b0);
    // Abort coinciding with last-pixel handshake.
    pix("s4b_start", 0, 1'b1, 1'b0, 1'b1);
    for (int p = 1; p < W * H; p++) pix("s4b_pix", p, 1'b0, 1'b0, 1'b1);
    idle("s4b_abort_last", 1'b0, 1'b1, 1'b0);
    idle("s4b_idle", 1'b0, 1'b0, 1'b0);
    // Start and abort together in IDLE.
    idle("s4c_start_abort", 1'b1, 1'b1, 1'b0);
    idle("s4c_idle", 1'b0, 1'b0, 1'b0);

    // Start during SCAN ignored; start in frame_done cycle restarts.
    pix("s5_start", 0, 1'b1, 1'b0, 1'b1);
    for (int p = 1; p < W * H; p++) pix("s5_pix", p, (p <= 3) ? 1'b1 : 1'b0, 1'b0, 1'b1);
    fc++;
    idle("s5_done", 1'b0, 1'b0, 1'b1);
    pix("s5_restart", 0, 1'b1, 1'b0, 1'b1);
    for (int p = 1; p < W * H; p++) pix("s5_pix2", p, 1'b0, 1'b0, 1'b1);
    fc++;
    idle("s5_done2", 1'b0, 1'b0, 1'b1);
    idle("s5_idle", 1'b0, 1'b0, 1'b0);

    // ---- reset ----
    #1 rst = 1'b0;
    #2 check("reset_vals", 1'b0, 0, 0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // ---- apply table ----
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // ---- async reset mid-frame at (2,2) ----
    begin
      vec_t v;
      v.tag = "s6_start"; v.st = 1'b1; v.co = 1'b0; v.ab = 1'b0; v.rdy = 1'b1;
      v.vld = 1'b1; v.x = 0; v.y = 0; v.bsy = 1'b1; v.done = 1'b0; v.cnt = fc;
      step(v);
      v.st = 1'b0;
      for (int p = 1; p <= 10; p++) begin
        v.tag = "s6_pix"; v.x = p % W; v.y = p / W;
        step(v);
      end
      #3 rst = 1'b0;
      #1 check("s6_async_clear", 1'b0, 0, 0, 1'b0, 1'b0, 0);
      @(posedge clk);
      #1 check("s6_held_reset", 1'b0, 0, 0, 1'b0, 1'b0, 0);
      rst = 1'b1;
      v.tag = "s6_after"; v.rdy = 1'b1; v.vld = 1'b0; v.x = 0; v.y = 0;
      v.bsy = 1'b0; v.done = 1'b0; v.cnt = 0;
      step(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
